multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS CPU. Sequences the shared datapath through fetch, decode,
//  execute, memory and writeback. Drives the ALU's 6-bit ALUsel and consumes its ZFlag for branches.
//  Handshakes with a single unified memory port (MemReq/MemReady) and flags bus timeouts.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles MemReq may stay high without MemReady before BusErr (range 1..255)
// PORTS
//  clk          in   1   single clock; all state changes on the rising edge
//  reset        in   1   synchronous, active-high
//  Instr        in   32  IR contents, valid from DECODE onward
//  ZFlag        in   1   ALU flag: 1 = branch condition true
//  MemReady     in   1   memory completes the current MemReq this cycle
//  MemReq       out  1   memory access request
//  MemWrite     out  1   1 = store (qualified by MemReq)
//  IorD         out  1   memory address: 0 = PC, 1 = ALUOut
//  IRWrite      out  1   latch memory read data into IR
//  PCWrite      out  1   PC load enable
//  PCSrc        out  2   00 = ALU result, 01 = branch target (datapath adder), 10 = jump target
//  ALUsrcA      out  1   0 = PC, 1 = rs
//  ALUsrcB      out  2   00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = zero-extended imm
//  ALUsel       out  6   ALU operation, encoded as the ALU expects
//  RegWrite     out  1   register-file write enable
//  RegDst       out  1   0 = rt, 1 = rd
//  MemtoReg     out  1   0 = ALUOut, 1 = memory data
//  InstrDone    out  1   one-cycle pulse in the final state of each instruction
//  IllegalInstr out  1   one-cycle pulse in DECODE for an unsupported opcode or funct
//  BusErr       out  1   sticky; cleared only by reset
// BEHAVIOUR
//  - Reset: while reset=1 all outputs are 0. On the next edge: state=FETCH, timeout counter=0, BusErr=0.
//    Reset overrides any in-flight access; an outstanding MemReq is simply dropped.
//  - Supported opcodes:
//    R-type 000000 with funct 100000/100010/100100/100101/101010; addi 001000; andi 001100;
//    ori 001101; lw 100011; sw 101011; beq 000100; bne 000101; j 000010.
//  - ALUsel: funct for R-type; opcode for every I-type (ALU/lw/sw/beq/bne);
//    100000 (add) for PC+4. All other states drive 000000.
//  - FETCH: MemReq=1, IorD=0. Hold until MemReady. In the MemReady cycle assert
//    IRWrite=1, PCWrite=1, PCSrc=00, ALUsrcA=0, ALUsrcB=01, ALUsel=100000; then go to DECODE.
//  - DECODE (1 cycle, no strobes):
//    R/addi/andi/ori -> EXEC; lw/sw -> ADDR; beq/bne -> BRANCH; j -> JUMP;
//    anything else -> pulse IllegalInstr and InstrDone, then FETCH (treated as NOP).
//  - EXEC: ALUsrcA=1. ALUsrcB=00 for R-type, 10 for addi, 11 for andi/ori. Then go to WB.
//  - WB: RegWrite=1, MemtoReg=0, RegDst=1 for R-type else 0, InstrDone=1; then FETCH.
//  - ADDR: ALUsrcA=1, ALUsrcB=10, ALUsel=opcode. Then go to MEM.
//  - MEM: MemReq=1, IorD=1, MemWrite=1 for sw. Hold until MemReady.
//    sw then goes to FETCH with InstrDone=1 in the MemReady cycle; lw then goes to WBMEM.
//  - WBMEM: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1; then FETCH.
//  - BRANCH: ALUsrcA=1, ALUsrcB=00, ALUsel=opcode, PCSrc=01, PCWrite=ZFlag, InstrDone=1; then FETCH.
//  - JUMP: PCWrite=1, PCSrc=10, InstrDone=1; then FETCH.
//  - Cycle counts with zero-wait memory (MemReady in the first request cycle):
//    R/I-ALU 4, lw 5, sw 4, beq/bne/j 3. Each memory wait cycle adds 1.
//  - Timeout: the counter increments every cycle MemReq=1 and MemReady=0, and clears on MemReady or
//    on leaving FETCH/MEM. When it reaches MEM_TIMEOUT: go to ERROR and set BusErr.
//    MemReady arriving in that same cycle wins: no error.
//  - ERROR: all strobes 0, BusErr=1, state held until reset.
//  - MemReq stays asserted and its address stays stable until MemReady; no request is abandoned
//    except by reset or timeout.
// TESTING
//  - Reset: reset=1 for 2 cycles mid-MEM of an lw -> all outputs 0; after release MemReq=1, IorD=0
//    (FETCH); BusErr=0.
//  - add (Instr=0x00221820), MemReady always 1 -> ALUsel=100000 in EXEC; RegWrite=1, RegDst=1 in
//    cycle 4; InstrDone on cycle 4.
//  - lw (0x8C220004), fetch MemReady delayed 3 cycles -> IRWrite only in the MemReady cycle;
//    MemReq/IorD=1 in MEM; MemtoReg=1, RegWrite=1 in WBMEM; 8 cycles total.
//  - beq (0x10220003) with ZFlag=1, then bne with ZFlag=0 -> PCWrite=1, PCSrc=01 for beq;
//    PCWrite=0 for bne; ALUsel=000100 / 000101.
//  - Illegal opcode 0x3F -> IllegalInstr and InstrDone pulse in DECODE; no RegWrite/MemReq until
//    the next FETCH.
//  - MemReady held 0 in MEM with MEM_TIMEOUT=16 -> BusErr=1 after 16 wait cycles; strobes stay 0;
//    only reset clears it.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM sequencing fetch/decode/execute/memory/writeback
// over a shared datapath and a single request/ready memory port with bus timeout detection.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        ZFlag,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  PCSrc,
    output logic        ALUsrcA,
    output logic [1:0]  ALUsrcB,
    output logic [5:0]  ALUsel,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        InstrDone,
    output logic        IllegalInstr,
    output logic        BusErr
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_WB     = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WBMEM  = 4'd6;
    localparam logic [3:0] S_BRANCH = 4'd7;
    localparam logic [3:0] S_JUMP   = 4'd8;
    localparam logic [3:0] S_ERROR  = 4'd9;
    localparam logic [3:0] S_IDLE   = 4'd15;

    logic [3:0] state_q, state_d, st;
    logic [7:0] cnt_q, cnt_d;
    logic       bus_err_q, bus_err_d;
    logic [5:0] opcode, funct;
    logic       is_r, is_addi, is_alu_i, is_lw, is_sw, is_br, is_j, legal;
    logic       mem_wait, timeout;
    logic       unused_bits;

    assign opcode      = Instr[31:26];
    assign funct       = Instr[5:0];
    assign unused_bits = ^Instr[25:6];
    assign is_r     = (opcode == 6'b000000) && (funct == 6'b100000 || funct == 6'b100010 ||
                      funct == 6'b100100 || funct == 6'b100101 || funct == 6'b101010);
    assign is_addi  = opcode == 6'b001000;
    assign is_alu_i = is_addi || opcode == 6'b001100 || opcode == 6'b001101;
    assign is_lw    = opcode == 6'b100011;
    assign is_sw    = opcode == 6'b101011;
    assign is_br    = opcode == 6'b000100 || opcode == 6'b000101;
    assign is_j     = opcode == 6'b000010;
    assign legal    = is_r || is_alu_i || is_lw || is_sw || is_br || is_j;

    // A wait cycle is any request cycle without MemReady; ready in the limit cycle still completes.
    assign mem_wait = (state_q == S_FETCH || state_q == S_MEM) && !MemReady;
    assign timeout  = mem_wait && cnt_q == 8'(MEM_TIMEOUT - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (mem_wait && !timeout) ? cnt_q + 8'd1 : 8'd0;
        bus_err_d = bus_err_q || timeout;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : timeout ? S_ERROR : S_FETCH;
            S_DECODE: state_d = (is_r || is_alu_i) ? S_EXEC : (is_lw || is_sw) ? S_ADDR :
                                is_br ? S_BRANCH : is_j ? S_JUMP : S_FETCH;
            S_EXEC:   state_d = S_WB;
            S_ADDR:   state_d = S_MEM;
            S_MEM:    state_d = MemReady ? (is_sw ? S_FETCH : S_WBMEM) : timeout ? S_ERROR : S_MEM;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Holding reset parks the decode on an unused code so every strobe reads 0.
    assign st = reset ? S_IDLE : state_q;

    always_comb begin
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCSrc        = 2'b00;
        ALUsrcA      = 1'b0;
        ALUsrcB      = 2'b00;
        ALUsel       = 6'b000000;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        InstrDone    = 1'b0;
        IllegalInstr = 1'b0;
        BusErr       = bus_err_q && !reset;
        case (st)
            S_FETCH: begin
                MemReq  = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
                ALUsrcB = MemReady ? 2'b01 : 2'b00;
                ALUsel  = MemReady ? 6'b100000 : 6'b000000;
            end
            S_DECODE: begin
                IllegalInstr = !legal;
                InstrDone    = !legal;
            end
            S_EXEC: begin
                ALUsrcA = 1'b1;
                ALUsrcB = is_r ? 2'b00 : is_addi ? 2'b10 : 2'b11;
                ALUsel  = is_r ? funct : opcode;
            end
            S_WB: begin
                RegWrite  = 1'b1;
                RegDst    = is_r;
                InstrDone = 1'b1;
            end
            S_ADDR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
                ALUsel  = opcode;
            end
            S_MEM: begin
                MemReq    = 1'b1;
                IorD      = 1'b1;
                MemWrite  = is_sw;
                InstrDone = is_sw && MemReady;
            end
            S_WBMEM: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUsrcA   = 1'b1;
                ALUsel    = opcode;
                PCSrc     = 2'b01;
                PCWrite   = ZFlag;
                InstrDone = 1'b1;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSrc     = 2'b10;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
